// File: rtl/star_node_receiver.sv
// Star-network node receiver: filters router output for the local node,
// buffers accepted packets in a show-ahead FIFO and counts rx/drop events.
module star_node_receiver #(
    parameter logic [3:0]  NODE_ID = 4'd5,
    parameter int unsigned DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pkt_in,
    input  logic [3:0]  pkt_port,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  rx_count,
    output logic [7:0]  drop_count,
    output logic        err_flag
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STAT_W = 8;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [STAT_W-1:0] rx_count_q, rx_count_d;
    logic [STAT_W-1:0] drop_count_q, drop_count_d;
    logic              err_q, err_d;

    logic              to_me_c;
    logic              xfer_c;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;

    // Handshake status is derived from registered occupancy only.
    always_comb begin
        pkt_ready  = (count_q != CNT_W'(DEPTH));
        out_valid  = (count_q != '0);
        out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
        rx_count   = rx_count_q;
        drop_count = drop_count_q;
        err_flag   = err_q;
    end

    // Classify the incoming transfer and decide push/pop/drop.
    always_comb begin
        to_me_c = (pkt_port == NODE_ID);
        xfer_c  = pkt_valid && pkt_ready && to_me_c;
        push_c  = xfer_c && (pkt_in[3:0] == NODE_ID);
        drop_c  = xfer_c && (pkt_in[3:0] != NODE_ID);
        pop_c   = out_valid && out_ready;
    end

    // Next-state for buffer, pointers, occupancy and statistics.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rx_count_d   = rx_count_q;
        drop_count_d = drop_count_q;
        err_d        = err_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = pkt_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            if (rx_count_q != {STAT_W{1'b1}}) begin
                rx_count_d = rx_count_q + STAT_W'(1);
            end
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop_c) begin
            err_d = 1'b1;
            if (drop_count_q != {STAT_W{1'b1}}) begin
                drop_count_d = drop_count_q + STAT_W'(1);
            end
        end
    end

    // Control and status registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rx_count_q   <= '0;
            drop_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rx_count_q   <= rx_count_d;
            drop_count_q <= drop_count_d;
            err_q        <= err_d;
        end
    end

    // Packet storage; stale contents are masked by occupancy after reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_star_node_receiver.sv
// Directed self-checking bench for star_node_receiver (NODE_ID=5, DEPTH=4).
module tb_star_node_receiver;

    logic        clk;
    logic        rst;
    logic [63:0] pkt_in;
    logic [3:0]  pkt_port;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  rx_count;
    logic [7:0]  drop_count;
    logic        err_flag;

    int n_cmp;
    int n_err;

    star_node_receiver #(.NODE_ID(4'd5), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_in     (pkt_in),
        .pkt_port   (pkt_port),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rx_count   (rx_count),
        .drop_count (drop_count),
        .err_flag   (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [7:0] tag);
        return {tag, 48'h0123_4567_89AB, 4'h1, 4'h5};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pkt_valid = 1'b0; pkt_port = 4'h0; pkt_in = '0; out_ready = 1'b0;
        #2;
        n_cmp++; if (pkt_ready !== 1'b1) begin n_err++; $display("FAIL reset_pkt_ready got %b exp 1", pkt_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 64'h0) begin n_err++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        n_cmp++; if (rx_count !== 8'd0) begin n_err++; $display("FAIL reset_rx got %0d exp 0", rx_count); end
        n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
        n_cmp++; if (err_flag !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err_flag); end
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_foreign();
        pkt_valid = 1'b1; pkt_port = 4'h2; pkt_in = mk(8'h01);
        tick();
        pkt_in = {56'hDEAD, 4'h0, 4'h2};
        tick();
        pkt_port = 4'hF; pkt_in = {56'hBEEF, 4'h0, 4'h3};
        tick();
        pkt_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL foreign_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (rx_count !== 8'd0) begin n_err++; $display("FAIL foreign_rx got %0d exp 0", rx_count); end
        n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL foreign_drop got %0d exp 0", drop_count); end
        n_cmp++; if (err_flag !== 1'b0) begin n_err++; $display("FAIL foreign_err got %b exp 0", err_flag); end
    endtask

    task automatic test_single();
        pkt_port = 4'h5; pkt_in = 64'hAB00_0000_0000_0005; pkt_valid = 1'b1; out_ready = 1'b0;
        tick();
        pkt_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
        n_cmp++; if (out_data !== 64'hAB00_0000_0000_0005) begin n_err++; $display("FAIL single_out_data got %h exp ab00000000000005", out_data); end
        n_cmp++; if (rx_count !== 8'd1) begin n_err++; $display("FAIL single_rx got %0d exp 1", rx_count); end
        tick();
        n_cmp++; if (out_data !== 64'hAB00_0000_0000_0005) begin n_err++; $display("FAIL single_hold got %h exp ab00000000000005", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop got %b exp 0", out_valid); end
    endtask

    task automatic test_misroute();
        pkt_port = 4'h5; pkt_in = {56'h77, 4'h1, 4'h3}; pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL misroute_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL misroute_drop got %0d exp 1", drop_count); end
        n_cmp++; if (err_flag !== 1'b1) begin n_err++; $display("FAIL misroute_err got %b exp 1", err_flag); end
        n_cmp++; if (rx_count !== 8'd1) begin n_err++; $display("FAIL misroute_rx got %0d exp 1", rx_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pkt_in = mk(8'(8'h10 + i)); pkt_valid = 1'b1;
            tick();
            n_cmp++; if (out_data !== mk(8'(8'h10 + i))) begin n_err++; $display("FAIL misroute_stream[%0d] got %h exp %h", i, out_data, mk(8'(8'h10 + i))); end
        end
        pkt_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL misroute_drain got %b exp 0", out_valid); end
        n_cmp++; if (rx_count !== 8'd11) begin n_err++; $display("FAIL misroute_rx_after got %0d exp 11", rx_count); end
        n_cmp++; if (drop_count !== 8'd1) begin n_err++; $display("FAIL misroute_drop_after got %0d exp 1", drop_count); end
        n_cmp++; if (err_flag !== 1'b1) begin n_err++; $display("FAIL misroute_sticky got %b exp 1", err_flag); end
    endtask

    task automatic test_fill_wrap();
        out_ready = 1'b0; pkt_port = 4'h5;
        for (int i = 0; i < 4; i++) begin
            pkt_in = mk(8'(8'h20 + i)); pkt_valid = 1'b1;
            tick();
        end
        pkt_valid = 1'b0;
        n_cmp++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL full_pkt_ready got %b exp 0", pkt_ready); end
        n_cmp++; if (out_data !== mk(8'h20)) begin n_err++; $display("FAIL full_head got %h exp %h", out_data, mk(8'h20)); end
        pkt_in = mk(8'h2F); pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        n_cmp++; if (rx_count !== 8'd15) begin n_err++; $display("FAIL full_reject_rx got %0d exp 15", rx_count); end
        n_cmp++; if (pkt_ready !== 1'b0) begin n_err++; $display("FAIL full_still got %b exp 0", pkt_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_data !== mk(8'(8'h20 + i))) begin n_err++; $display("FAIL drain[%0d] got %h exp %h", i, out_data, mk(8'(8'h20 + i))); end
            tick();
            n_cmp++; if (pkt_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready[%0d] got %b exp 1", i, pkt_ready); end
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b exp 0", out_valid); end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                pkt_in = mk(8'(8'h30 + 3 * r + i)); pkt_valid = 1'b1;
                tick();
            end
            pkt_valid = 1'b0; out_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (out_data !== mk(8'(8'h30 + 3 * r + i))) begin n_err++; $display("FAIL wrap[%0d][%0d] got %h exp %h", r, i, out_data, mk(8'(8'h30 + 3 * r + i))); end
                tick();
            end
            out_ready = 1'b0;
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty got %b exp 0", out_valid); end
        n_cmp++; if (rx_count !== 8'd21) begin n_err++; $display("FAIL wrap_rx got %0d exp 21", rx_count); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] q[$];
        out_ready = 1'b0; pkt_port = 4'h5;
        for (int i = 0; i < 2; i++) begin
            pkt_in = mk(8'(8'h40 + i)); pkt_valid = 1'b1; q.push_back(mk(8'(8'h40 + i)));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pkt_in = mk(8'(8'h50 + i)); pkt_valid = 1'b1;
            n_cmp++; if (out_data !== q[0]) begin n_err++; $display("FAIL b2b[%0d] got %h exp %h", i, out_data, q[0]); end
            tick();
            void'(q.pop_front());
            q.push_back(mk(8'(8'h50 + i)));
        end
        pkt_valid = 1'b0;
        n_cmp++; if (rx_count !== 8'd43) begin n_err++; $display("FAIL b2b_rx got %0d exp 43", rx_count); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== q[0]) begin n_err++; $display("FAIL b2b_drain[%0d] got %b/%h exp 1/%h", i, out_valid, out_data, q[0]); end
            tick();
            void'(q.pop_front());
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_occupancy got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; pkt_port = 4'h5;
        for (int i = 0; i < 3; i++) begin
            pkt_in = mk(8'(8'h60 + i)); pkt_valid = 1'b1;
            tick();
        end
        pkt_valid = 1'b0;
        pkt_port = 4'h5; pkt_in = {56'h1, 4'h0, 4'h9}; pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        n_cmp++; if (err_flag !== 1'b1) begin n_err++; $display("FAIL pre_reset_err got %b exp 1", err_flag); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 64'h0) begin n_err++; $display("FAIL mid_reset_out_data got %h exp 0", out_data); end
        n_cmp++; if (pkt_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_pkt_ready got %b exp 1", pkt_ready); end
        n_cmp++; if (rx_count !== 8'd0) begin n_err++; $display("FAIL mid_reset_rx got %0d exp 0", rx_count); end
        n_cmp++; if (drop_count !== 8'd0) begin n_err++; $display("FAIL mid_reset_drop got %0d exp 0", drop_count); end
        n_cmp++; if (err_flag !== 1'b0) begin n_err++; $display("FAIL mid_reset_err got %b exp 0", err_flag); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid got %b exp 0", out_valid); end
        pkt_in = mk(8'h77); pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== mk(8'h77)) begin n_err++; $display("FAIL first_after_reset got %b/%h exp 1/%h", out_valid, out_data, mk(8'h77)); end
        n_cmp++; if (rx_count !== 8'd1) begin n_err++; $display("FAIL first_after_reset_rx got %0d exp 1", rx_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_foreign();
        test_single();
        test_misroute();
        test_fill_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
